// File: rtl/if_c_ext_pkg.sv
// Shared definitions for the RV32C fetch path: parcel type and compressed-encoding helpers.
package if_c_ext_pkg;

    localparam int PARCEL_W = 16;

    typedef logic [PARCEL_W-1:0] parcel_t;

    // c.nop (c.addi x0, 0)
    localparam parcel_t C_NOP = 16'h0001;

    function automatic logic is_compressed(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/parcel_ring_buffer.sv
// Circular parcel storage: FP-wide masked write at wr_ptr, two read ports at rd_ptr and rd_ptr+1.
module parcel_ring_buffer
    import if_c_ext_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int FP    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [$clog2(DEPTH)-1:0]  i_wr_ptr,
    input  logic [FP-1:0]             i_wr_mask,
    input  logic [FP*PARCEL_W-1:0]    i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]  i_rd_ptr,
    output parcel_t                   o_rd0,
    output parcel_t                   o_rd1
);

    localparam int PTR_W = $clog2(DEPTH);

    parcel_t mem_q [DEPTH];
    parcel_t mem_d [DEPTH];

    // Storage needs no reset: occupancy in the top decides what is ever read as valid.
    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            for (int j = 0; j < FP; j++) begin
                if (i_wr_mask[j]) begin
                    mem_d[i_wr_ptr + PTR_W'(j)] = i_wr_data[j*PARCEL_W +: PARCEL_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_rd0 = mem_q[i_rd_ptr];
    assign o_rd1 = mem_q[PTR_W'(i_rd_ptr + 1'b1)];

endmodule

// File: rtl/instruction_parcel_queue.sv
// Fetch-side realigner: queues 16-bit parcels from aligned fetch blocks and emits one raw RV32C instruction per cycle.
module instruction_parcel_queue
    import if_c_ext_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          FETCH_WIDTH = 32,
    parameter int          DEPTH       = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_fetch_valid,
    output logic                     o_fetch_ready,
    input  logic [FETCH_WIDTH-1:0]   i_fetch_data,
    input  logic                     i_flush,
    input  logic [XLEN-1:0]          i_flush_pc,
    output logic                     o_instr_valid,
    input  logic                     i_instr_ready,
    output logic [31:0]              o_instr,
    output logic                     o_is_compressed,
    output logic [XLEN-1:0]          o_instr_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int FP     = FETCH_WIDTH / PARCEL_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SKIP_W = $clog2(FP);

    if ((FETCH_WIDTH != 32 && FETCH_WIDTH != 64) || ((DEPTH & (DEPTH - 1)) != 0)
        || (DEPTH < 2 * FP) || (RESET_PC[0] != 1'b0)) begin : g_bad_params
        $fatal(1, "instruction_parcel_queue: illegal parameter combination");
    end

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [SKIP_W-1:0] skip_q, skip_d;

    parcel_t                head_lo, head_hi;
    logic                   head_c;
    logic                   enq, deq;
    logic [CNT_W-1:0]       written, consumed;
    logic [FP-1:0]          wr_mask;
    logic [FETCH_WIDTH-1:0] wr_block;

    parcel_ring_buffer #(
        .DEPTH (DEPTH),
        .FP    (FP)
    ) u_ring (
        .i_clk     (i_clk),
        .i_we      (enq),
        .i_wr_ptr  (wr_ptr_q),
        .i_wr_mask (wr_mask),
        .i_wr_data (wr_block),
        .i_rd_ptr  (rd_ptr_q),
        .o_rd0     (head_lo),
        .o_rd1     (head_hi)
    );

    // After a redirect to a mid-block halfword, the leading parcels of the next block are not ours.
    always_comb begin
        written  = CNT_W'(FP) - CNT_W'(skip_q);
        wr_block = i_fetch_data >> {skip_q, 4'b0000};
        for (int j = 0; j < FP; j++) begin
            wr_mask[j] = CNT_W'(j) < written;
        end
    end

    always_comb begin
        head_c          = is_compressed(head_lo);
        consumed        = head_c ? CNT_W'(1) : CNT_W'(2);
        o_fetch_ready   = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FP);
        o_instr_valid   = !i_flush && (count_q != '0) && (head_c || count_q >= CNT_W'(2));
        o_is_compressed = (count_q != '0) && head_c;
        o_instr_pc      = pc_q;
        o_count         = count_q;
        o_instr         = 32'h0;
        if (o_instr_valid) begin
            o_instr = head_c ? {16'h0000, head_lo} : {head_hi, head_lo};
        end
        enq = i_fetch_valid && o_fetch_ready && !i_flush;
        deq = o_instr_valid && i_instr_ready;
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
        skip_d   = skip_q;
        if (i_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = i_flush_pc;
            skip_d   = i_flush_pc[SKIP_W:1];
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(written);
                skip_d   = '0;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(consumed);
                pc_d     = pc_q + (head_c ? XLEN'(2) : XLEN'(4));
            end
            count_d = count_q + (enq ? written : CNT_W'(0)) - (deq ? consumed : CNT_W'(0));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pc_q     <= XLEN'(RESET_PC);
            skip_q   <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pc_q     <= pc_d;
            skip_q   <= skip_d;
        end
    end

endmodule

// File: tb/tb_instruction_parcel_queue.sv
// Scoreboard bench for instruction_parcel_queue: a 32-bit-fetch and a 64-bit-fetch instance.
module tb_instruction_parcel_queue;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_fv, a_fl, a_rdy, a_frdy, a_iv, a_ic;
    logic [31:0] a_fd, a_fpc, a_instr, a_pc;
    logic [3:0]  a_cnt;

    logic        b_fv, b_fl, b_rdy, b_frdy, b_iv, b_ic;
    logic [63:0] b_fd;
    logic [31:0] b_fpc, b_instr, b_pc;
    logic [3:0]  b_cnt;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    int   tests = 0;
    int   fails = 0;

    instruction_parcel_queue #(.XLEN(32), .FETCH_WIDTH(32), .DEPTH(8), .RESET_PC(32'h0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_fetch_valid(a_fv), .o_fetch_ready(a_frdy),
        .i_fetch_data(a_fd), .i_flush(a_fl), .i_flush_pc(a_fpc), .o_instr_valid(a_iv),
        .i_instr_ready(a_rdy), .o_instr(a_instr), .o_is_compressed(a_ic),
        .o_instr_pc(a_pc), .o_count(a_cnt)
    );

    instruction_parcel_queue #(.XLEN(32), .FETCH_WIDTH(64), .DEPTH(8), .RESET_PC(32'h0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_fetch_valid(b_fv), .o_fetch_ready(b_frdy),
        .i_fetch_data(b_fd), .i_flush(b_fl), .i_flush_pc(b_fpc), .o_instr_valid(b_iv),
        .i_instr_ready(b_rdy), .o_instr(b_instr), .o_is_compressed(b_ic),
        .o_instr_pc(b_pc), .o_count(b_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic fv, input logic [63:0] fd,
                                 input logic fl, input logic [31:0] fpc, input logic rdy);
        if (sel == 1'b0) begin
            a_fv = fv; a_fd = fd[31:0]; a_fl = fl; a_fpc = fpc; a_rdy = rdy;
        end else begin
            b_fv = fv; b_fd = fd; b_fl = fl; b_fpc = fpc; b_rdy = rdy;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic c);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.c     = c;
        return e;
    endfunction

    // Monitors pop the scoreboard whenever a head instruction is handed over.
    always @(negedge clk) begin
        if (!rst && a_iv && a_rdy) begin
            if (exp_a.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL a_unexpected: got instr 0x%0h pc 0x%0h, expected none", a_instr, a_pc);
            end else begin
                ea = exp_a.pop_front();
                checkOutput("a_instr", a_instr, ea.instr);
                checkOutput("a_pc", a_pc, ea.pc);
                checkOutput("a_is_c", {31'b0, a_ic}, {31'b0, ea.c});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_iv && b_rdy) begin
            if (exp_b.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL b_unexpected: got instr 0x%0h pc 0x%0h, expected none", b_instr, b_pc);
            end else begin
                eb = exp_b.pop_front();
                checkOutput("b_instr", b_instr, eb.instr);
                checkOutput("b_pc", b_pc, eb.pc);
                checkOutput("b_is_c", {31'b0, b_ic}, {31'b0, eb.c});
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("a_rst_count", {28'b0, a_cnt}, 32'd0);
        checkOutput("a_rst_valid", {31'b0, a_iv}, 32'd0);
        checkOutput("a_rst_fready", {31'b0, a_frdy}, 32'd1);
        checkOutput("a_rst_instr", a_instr, 32'h0);
        checkOutput("a_rst_is_c", {31'b0, a_ic}, 32'd0);
        checkOutput("b_rst_count", {28'b0, b_cnt}, 32'd0);
        checkOutput("b_rst_fready", {31'b0, b_frdy}, 32'd1);
        nextCycle();

        // Two compressed c.li in one block
        exp_a.push_back(mk(32'h0000_4505, 32'h0, 1'b1));
        exp_a.push_back(mk(32'h0000_4501, 32'h2, 1'b1));
        applyStimulus(0, 1, 64'h4501_4505, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 1);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("t1_count", {28'b0, a_cnt}, 32'd0);

        // Redirect to halfword PC, 32-bit instruction spanning two blocks
        applyStimulus(0, 0, 64'h0, 1, 32'h102, 1);
        @(negedge clk);
        checkOutput("t2_flush_valid", {31'b0, a_iv}, 32'd0);
        nextCycle();
        applyStimulus(0, 1, 64'h0613_0001, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 1);
        @(negedge clk);
        checkOutput("t2_span_count", {28'b0, a_cnt}, 32'd1);
        checkOutput("t2_span_valid", {31'b0, a_iv}, 32'd0);
        exp_a.push_back(mk(32'h0050_0613, 32'h102, 1'b0));
        exp_a.push_back(mk(32'h0000_4505, 32'h106, 1'b1));
        applyStimulus(0, 1, 64'h4505_0050, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 1);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("t2_count", {28'b0, a_cnt}, 32'd0);

        // Flush colliding with a fetch and a valid head
        applyStimulus(0, 1, 64'h4501_4505, 0, 32'h0, 0);
        nextCycle();
        applyStimulus(0, 1, 64'h1111_2222, 1, 32'h200, 1);
        @(negedge clk);
        checkOutput("t5_flush_valid", {31'b0, a_iv}, 32'd0);
        checkOutput("t5_pre_count", {28'b0, a_cnt}, 32'd2);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 1);
        @(negedge clk);
        checkOutput("t5_count", {28'b0, a_cnt}, 32'd0);
        checkOutput("t5_valid", {31'b0, a_iv}, 32'd0);
        exp_a.push_back(mk(32'h0000_4505, 32'h200, 1'b1));
        exp_a.push_back(mk(32'h0000_0001, 32'h202, 1'b1));
        applyStimulus(0, 1, 64'h0001_4505, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 1);
        nextCycle();
        nextCycle();

        // 64-bit fetch: fill to full, drain, then wrap a 32-bit instruction over slots 7/0
        applyStimulus(1, 1, 64'h0020_0593_0010_0513, 0, 32'h0, 0);
        nextCycle();
        applyStimulus(1, 1, 64'h0713_4505_0030_0613, 0, 32'h0, 0);
        nextCycle();
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("t3_full_count", {28'b0, b_cnt}, 32'd8);
        checkOutput("t3_full_fready", {31'b0, b_frdy}, 32'd0);
        checkOutput("t3_full_valid", {31'b0, b_iv}, 32'd1);
        nextCycle();
        exp_b.push_back(mk(32'h0010_0513, 32'h0, 1'b0));
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("t3_count6", {28'b0, b_cnt}, 32'd6);
        checkOutput("t3_fready6", {31'b0, b_frdy}, 32'd0);
        nextCycle();
        exp_b.push_back(mk(32'h0020_0593, 32'h4, 1'b0));
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("t3_count4", {28'b0, b_cnt}, 32'd4);
        checkOutput("t3_fready4", {31'b0, b_frdy}, 32'd1);
        nextCycle();
        applyStimulus(1, 1, 64'h0060_0793_4509_0050, 0, 32'h0, 0);
        nextCycle();
        exp_b.push_back(mk(32'h0030_0613, 32'h8, 1'b0));
        exp_b.push_back(mk(32'h0000_4505, 32'hC, 1'b1));
        exp_b.push_back(mk(32'h0050_0713, 32'hE, 1'b0));
        exp_b.push_back(mk(32'h0000_4509, 32'h12, 1'b1));
        exp_b.push_back(mk(32'h0060_0793, 32'h14, 1'b0));
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 1);
        repeat (5) nextCycle();
        applyStimulus(1, 0, 64'h0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("t4_count", {28'b0, b_cnt}, 32'd0);
        nextCycle();

        // Reset in the middle of a partly filled queue
        applyStimulus(0, 0, 64'h0, 1, 32'h302, 0);
        nextCycle();
        applyStimulus(0, 1, 64'h4505_4505, 0, 32'h0, 0);
        repeat (3) nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("t6_pre_count", {28'b0, a_cnt}, 32'd5);
        checkOutput("t6_pre_fready", {31'b0, a_frdy}, 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_count", {28'b0, a_cnt}, 32'd0);
        checkOutput("t6_valid", {31'b0, a_iv}, 32'd0);
        checkOutput("t6_fready", {31'b0, a_frdy}, 32'd1);
        exp_a.push_back(mk(32'h0000_4501, 32'h0, 1'b1));
        exp_a.push_back(mk(32'h0000_4505, 32'h2, 1'b1));
        applyStimulus(0, 1, 64'h4505_4501, 0, 32'h0, 1);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 32'h0, 1);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("t6_end_count", {28'b0, a_cnt}, 32'd0);

        checkOutput("a_scoreboard_left", exp_a.size(), 32'd0);
        checkOutput("b_scoreboard_left", exp_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
